tile_seq: RTL and testbench

- Sequencer that runs a multi-tile matrix operation on the accelerator.
- Accepts one command, then for each tile: loads weights into the weighting buffer, loads activations from the unified buffer, starts the systolic array, and stores the result back through the unified buffer.
- Sits between the host-facing command register block and the unified buffer, weighting buffer and array.

---
 rtl/tile_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_tile_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_seq.sv
// rtl/tile_seq.sv - multi-tile sequencer: weight load, activation load, array run, result store per tile
// Optional feature macro TILE_SEQ_OVERLAP_EN: parallel weight/activation loads and next-tile weight prefetch.
module tile_seq #(
  parameter int AW = 32,
  parameter int DW = 10,
  parameter int NT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_act_addr,
  input  logic [AW-1:0] cmd_wei_addr,
  input  logic [AW-1:0] cmd_out_addr,
  input  logic [DW-1:0] cmd_row,
  input  logic [DW-1:0] cmd_col,
  input  logic [NT-1:0] cmd_ntiles,
  input  logic          uni_ready,
  input  logic          uni_busy,
  output logic          uni_load,
  output logic          uni_type,
  output logic [AW-1:0] uni_init_addr,
  output logic [AW-1:0] uni_out_addr,
  output logic [DW-1:0] uni_row,
  output logic [DW-1:0] uni_col,
  input  logic          wei_ready,
  input  logic          wei_busy,
  output logic          wei_load,
  output logic [AW-1:0] wei_init_addr,
  output logic [DW-1:0] wei_row,
  output logic [DW-1:0] wei_col,
  output logic          arr_start,
  input  logic          arr_done,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_WEI, S_WT_WEI, S_LD_ACT, S_WT_ACT, S_RUN,
    S_WT_RUN, S_ST, S_WT_ST, S_NEXT, S_LD_BOTH, S_WT_BOTH
  } state_t;

`ifdef TILE_SEQ_OVERLAP_EN
  localparam state_t S_TILE_START = S_LD_BOTH;
`else
  localparam state_t S_TILE_START = S_LD_WEI;
`endif

  state_t        r_state, w_state;
  logic [AW-1:0] r_act_ptr, r_wei_ptr, r_out_ptr, w_act_ptr, w_wei_ptr, w_out_ptr;
  logic [DW-1:0] r_row, r_col, w_row, w_col;
  logic [NT-1:0] r_ntiles, r_tile_cnt, w_ntiles, w_tile_cnt;
  logic          r_seen, w_seen;
  logic          r_w_iss, r_w_seen, r_w_fin, w_w_iss, w_w_seen, w_w_fin;
  logic          r_a_iss, r_a_seen, r_a_fin, w_a_iss, w_a_seen, w_a_fin;

  logic          r_cmd_ready, r_busy, r_done, r_err, w_cmd_ready, w_busy, w_done, w_err;
  logic          r_uni_load, r_uni_type, w_uni_load, w_uni_type;
  logic [AW-1:0] r_uni_init_addr, r_uni_out_addr, w_uni_init_addr, w_uni_out_addr;
  logic [DW-1:0] r_uni_row, r_uni_col, w_uni_row, w_uni_col;
  logic          r_wei_load, w_wei_load;
  logic [AW-1:0] r_wei_init_addr, w_wei_init_addr;
  logic [DW-1:0] r_wei_row, r_wei_col, w_wei_row, w_wei_col;
  logic          r_arr_start, w_arr_start;

  logic [2*DW-1:0] w_prod;
  logic [AW-1:0]   w_sz;
  logic            w_last;

  assign w_prod = {{DW{1'b0}}, r_row} * {{DW{1'b0}}, r_col};
  assign w_sz   = AW'(w_prod);
  assign w_last = (r_tile_cnt + NT'(1)) == r_ntiles;

  always_comb begin
    w_state         = r_state;
    w_act_ptr       = r_act_ptr;
    w_wei_ptr       = r_wei_ptr;
    w_out_ptr       = r_out_ptr;
    w_row           = r_row;
    w_col           = r_col;
    w_ntiles        = r_ntiles;
    w_tile_cnt      = r_tile_cnt;
    w_seen          = r_seen;
    w_w_iss         = r_w_iss;
    w_w_seen        = r_w_seen;
    w_w_fin         = r_w_fin;
    w_a_iss         = r_a_iss;
    w_a_seen        = r_a_seen;
    w_a_fin         = r_a_fin;
    w_uni_type      = r_uni_type;
    w_uni_init_addr = r_uni_init_addr;
    w_uni_out_addr  = r_uni_out_addr;
    w_uni_row       = r_uni_row;
    w_uni_col       = r_uni_col;
    w_wei_init_addr = r_wei_init_addr;
    w_wei_row       = r_wei_row;
    w_wei_col       = r_wei_col;
    w_uni_load      = 1'b0;
    w_wei_load      = 1'b0;
    w_arr_start     = 1'b0;
    w_done          = 1'b0;
    w_err           = 1'b0;

`ifdef TILE_SEQ_OVERLAP_EN
    // Completion tracking runs in any state so a prefetched weight load can finish during WT_ST.
    if (r_w_iss && !r_w_fin) begin
      if (r_w_seen && !wei_busy) begin
        w_w_fin  = 1'b1;
        w_w_seen = 1'b0;
      end else if (wei_busy) begin
        w_w_seen = 1'b1;
      end
    end
    if (r_a_iss && !r_a_fin) begin
      if (r_a_seen && !uni_busy) begin
        w_a_fin  = 1'b1;
        w_a_seen = 1'b0;
      end else if (uni_busy) begin
        w_a_seen = 1'b1;
      end
    end
`endif

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_act_ptr  = cmd_act_addr;
          w_wei_ptr  = cmd_wei_addr;
          w_out_ptr  = cmd_out_addr;
          w_row      = cmd_row;
          w_col      = cmd_col;
          w_ntiles   = (cmd_ntiles == '0) ? NT'(1) : cmd_ntiles;
          w_tile_cnt = '0;
          w_seen     = 1'b0;
          w_w_iss    = 1'b0;
          w_w_seen   = 1'b0;
          w_w_fin    = 1'b0;
          w_a_iss    = 1'b0;
          w_a_seen   = 1'b0;
          w_a_fin    = 1'b0;
          if (cmd_row == '0 || cmd_col == '0) begin
            w_done = 1'b1;
            w_err  = 1'b1;
          end else begin
            w_state = S_TILE_START;
          end
        end
      end
      S_LD_WEI: begin
        if (wei_ready && !wei_busy) begin
          w_wei_load      = 1'b1;
          w_wei_init_addr = r_wei_ptr;
          w_wei_row       = r_row;
          w_wei_col       = r_col;
          w_state         = S_WT_WEI;
        end
      end
      S_WT_WEI: begin
        if (r_seen && !wei_busy) begin
          w_seen  = 1'b0;
          w_state = S_LD_ACT;
        end else if (wei_busy) begin
          w_seen = 1'b1;
        end
      end
      S_LD_ACT: begin
        if (uni_ready && !uni_busy) begin
          w_uni_load      = 1'b1;
          w_uni_type      = 1'b0;
          w_uni_init_addr = r_act_ptr;
          w_uni_row       = r_row;
          w_uni_col       = r_col;
          w_state         = S_WT_ACT;
        end
      end
      S_WT_ACT: begin
        if (r_seen && !uni_busy) begin
          w_seen  = 1'b0;
          w_state = S_RUN;
        end else if (uni_busy) begin
          w_seen = 1'b1;
        end
      end
      S_RUN: begin
        w_arr_start = 1'b1;
        w_state     = S_WT_RUN;
      end
      S_WT_RUN: begin
        if (arr_done) w_state = S_ST;
      end
      S_ST: begin
        if (uni_ready && !uni_busy) begin
          w_uni_load     = 1'b1;
          w_uni_type     = 1'b1;
          w_uni_out_addr = r_out_ptr;
          w_uni_row      = r_row;
          w_uni_col      = r_col;
          w_state        = S_WT_ST;
        end
      end
      S_WT_ST: begin
        if (r_seen && !uni_busy) begin
          w_seen  = 1'b0;
          w_state = S_NEXT;
        end else if (uni_busy) begin
          w_seen = 1'b1;
        end
`ifdef TILE_SEQ_OVERLAP_EN
        if (!r_w_iss && !w_last && wei_ready && !wei_busy) begin
          w_wei_load      = 1'b1;
          w_wei_init_addr = r_wei_ptr + w_sz;
          w_wei_row       = r_row;
          w_wei_col       = r_col;
          w_w_iss         = 1'b1;
        end
`endif
      end
      S_NEXT: begin
        if (w_last) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_tile_cnt = r_tile_cnt + NT'(1);
          w_act_ptr  = r_act_ptr + w_sz;
          w_wei_ptr  = r_wei_ptr + w_sz;
          w_out_ptr  = r_out_ptr + w_sz;
          w_state    = S_TILE_START;
        end
      end
`ifdef TILE_SEQ_OVERLAP_EN
      S_LD_BOTH: begin
        if (!r_w_iss && wei_ready && !wei_busy) begin
          w_wei_load      = 1'b1;
          w_wei_init_addr = r_wei_ptr;
          w_wei_row       = r_row;
          w_wei_col       = r_col;
          w_w_iss         = 1'b1;
        end
        if (!r_a_iss && uni_ready && !uni_busy) begin
          w_uni_load      = 1'b1;
          w_uni_type      = 1'b0;
          w_uni_init_addr = r_act_ptr;
          w_uni_row       = r_row;
          w_uni_col       = r_col;
          w_a_iss         = 1'b1;
        end
        if (w_w_iss && w_a_iss) w_state = S_WT_BOTH;
      end
      S_WT_BOTH: begin
        if (r_w_fin && r_a_fin) begin
          w_w_iss  = 1'b0;
          w_w_seen = 1'b0;
          w_w_fin  = 1'b0;
          w_a_iss  = 1'b0;
          w_a_seen = 1'b0;
          w_a_fin  = 1'b0;
          w_state  = S_RUN;
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase

    w_busy      = (w_state != S_IDLE);
    w_cmd_ready = (w_state == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_act_ptr       <= '0;
      r_wei_ptr       <= '0;
      r_out_ptr       <= '0;
      r_row           <= '0;
      r_col           <= '0;
      r_ntiles        <= '0;
      r_tile_cnt      <= '0;
      r_seen          <= 1'b0;
      r_w_iss         <= 1'b0;
      r_w_seen        <= 1'b0;
      r_w_fin         <= 1'b0;
      r_a_iss         <= 1'b0;
      r_a_seen        <= 1'b0;
      r_a_fin         <= 1'b0;
      r_cmd_ready     <= 1'b1;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_uni_load      <= 1'b0;
      r_uni_type      <= 1'b0;
      r_uni_init_addr <= '0;
      r_uni_out_addr  <= '0;
      r_uni_row       <= '0;
      r_uni_col       <= '0;
      r_wei_load      <= 1'b0;
      r_wei_init_addr <= '0;
      r_wei_row       <= '0;
      r_wei_col       <= '0;
      r_arr_start     <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_act_ptr       <= w_act_ptr;
      r_wei_ptr       <= w_wei_ptr;
      r_out_ptr       <= w_out_ptr;
      r_row           <= w_row;
      r_col           <= w_col;
      r_ntiles        <= w_ntiles;
      r_tile_cnt      <= w_tile_cnt;
      r_seen          <= w_seen;
      r_w_iss         <= w_w_iss;
      r_w_seen        <= w_w_seen;
      r_w_fin         <= w_w_fin;
      r_a_iss         <= w_a_iss;
      r_a_seen        <= w_a_seen;
      r_a_fin         <= w_a_fin;
      r_cmd_ready     <= w_cmd_ready;
      r_busy          <= w_busy;
      r_done          <= w_done;
      r_err           <= w_err;
      r_uni_load      <= w_uni_load;
      r_uni_type      <= w_uni_type;
      r_uni_init_addr <= w_uni_init_addr;
      r_uni_out_addr  <= w_uni_out_addr;
      r_uni_row       <= w_uni_row;
      r_uni_col       <= w_uni_col;
      r_wei_load      <= w_wei_load;
      r_wei_init_addr <= w_wei_init_addr;
      r_wei_row       <= w_wei_row;
      r_wei_col       <= w_wei_col;
      r_arr_start     <= w_arr_start;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign uni_load      = r_uni_load;
  assign uni_type      = r_uni_type;
  assign uni_init_addr = r_uni_init_addr;
  assign uni_out_addr  = r_uni_out_addr;
  assign uni_row       = r_uni_row;
  assign uni_col       = r_uni_col;
  assign wei_load      = r_wei_load;
  assign wei_init_addr = r_wei_init_addr;
  assign wei_row       = r_wei_row;
  assign wei_col       = r_wei_col;
  assign arr_start     = r_arr_start;

endmodule

// File: tb/tb_tile_seq.sv
// tb/tb_tile_seq.sv - directed and randomized bench for tile_seq with buffer/array responders
// Expected request streams come from a per-tile address model of each command.
module tb_tile_seq;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_act_addr, cmd_wei_addr, cmd_out_addr;
  logic [9:0]  cmd_row, cmd_col;
  logic [7:0]  cmd_ntiles;
  logic        uni_ready, uni_busy, uni_load, uni_type;
  logic [31:0] uni_init_addr, uni_out_addr;
  logic [9:0]  uni_row, uni_col;
  logic        wei_ready, wei_busy, wei_load;
  logic [31:0] wei_init_addr;
  logic [9:0]  wei_row, wei_col;
  logic        arr_start, arr_done, busy, done, err;

  tile_seq dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_act_addr(cmd_act_addr), .cmd_wei_addr(cmd_wei_addr), .cmd_out_addr(cmd_out_addr),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ntiles(cmd_ntiles),
    .uni_ready(uni_ready), .uni_busy(uni_busy), .uni_load(uni_load), .uni_type(uni_type),
    .uni_init_addr(uni_init_addr), .uni_out_addr(uni_out_addr),
    .uni_row(uni_row), .uni_col(uni_col),
    .wei_ready(wei_ready), .wei_busy(wei_busy), .wei_load(wei_load),
    .wei_init_addr(wei_init_addr), .wei_row(wei_row), .wei_col(wei_col),
    .arr_start(arr_start), .arr_done(arr_done),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event word: {kind, addr, row, col}; kind 0=weight, 1=activation, 2=store, 3=array start.
  typedef logic [53:0] ev_t;
  ev_t ev_q[$];
  ev_t exp_q[$];

  int  n_checks = 0;
  int  n_fail = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  exp_done = 0;
  int  exp_err = 0;
  bit  cur_err;
  bit  rnd_en = 1'b0;
  bit  uni_hold = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic build_exp(input logic [31:0] a, input logic [31:0] w, input logic [31:0] o,
                           input logic [9:0] r, input logic [9:0] c, input logic [7:0] n);
    logic [31:0] sz, off;
    int tiles;
    exp_q.delete();
    cur_err = (r == 0) || (c == 0);
    if (cur_err) return;
    sz = 32'(r) * 32'(c);
    tiles = (n == 0) ? 1 : int'(n);
    for (int t = 0; t < tiles; t++) begin
      off = sz * 32'(t);
      exp_q.push_back({2'd0, w + off, r, c});
      exp_q.push_back({2'd1, a + off, r, c});
      exp_q.push_back({2'd3, 32'd0, 10'd0, 10'd0});
      exp_q.push_back({2'd2, o + off, r, c});
    end
  endtask

  // Called on a falling edge; returns on the falling edge right after acceptance.
  task automatic start_cmd(input logic [31:0] a, input logic [31:0] w, input logic [31:0] o,
                           input logic [9:0] r, input logic [9:0] c, input logic [7:0] n);
    int k;
    build_exp(a, w, o, r, c, n);
    ev_q.delete();
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    cmd_act_addr = a; cmd_wei_addr = w; cmd_out_addr = o;
    cmd_row = r; cmd_col = c; cmd_ntiles = n;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (cur_err) begin
      check("zero_dim_done_t1", 64'(done), 64'd1);
      check("zero_dim_err_t1", 64'(err), 64'd1);
    end else begin
      check("busy_t1", 64'(busy), 64'd1);
      check("cmd_ready_low_t1", 64'(cmd_ready), 64'd0);
      check("no_wei_load_t1", 64'(wei_load), 64'd0);
    end
  endtask

  task automatic finish_cmd();
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("err_at_done", 64'(err), 64'(cur_err));
    check("busy_low_at_done", 64'(busy), 64'd0);
    check("cmd_ready_at_done", 64'(cmd_ready), 64'd1);
    check("event_count", 64'(ev_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check($sformatf("event_%0d", i), 64'(ev_q[i]), 64'(exp_q[i]));
    exp_done++;
    if (cur_err) exp_err++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_ctl"}, 64'({busy, done, err, uni_load, uni_type, wei_load, arr_start}), 64'd0);
    check({tag, "_uni_addr"}, {uni_init_addr, uni_out_addr}, 64'd0);
    check({tag, "_dims"}, 64'({uni_row, uni_col, wei_row, wei_col}), 64'd0);
    check({tag, "_wei_addr"}, 64'(wei_init_addr), 64'd0);
  endtask

  // Monitor first (inputs still hold the values sampled at the last rising edge), then responders.
  int wei_gap = 0, wei_left = 0, uni_gap = 0, uni_left = 0, arr_wait = 0;
  logic [31:0] prev_wei_addr = '0, prev_uni_addr = '0;
  initial begin
    wei_ready = 1'b1; wei_busy = 1'b0; uni_ready = 1'b1; uni_busy = 1'b0; arr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (wei_load) begin
          ev_q.push_back({2'd0, wei_init_addr, wei_row, wei_col});
          check("wei_issue_cond", 64'(wei_ready && !wei_busy), 64'd1);
        end else begin
          check("wei_addr_hold", 64'(wei_init_addr), 64'(prev_wei_addr));
        end
        if (uni_load) begin
          if (uni_type) ev_q.push_back({2'd2, uni_out_addr, uni_row, uni_col});
          else          ev_q.push_back({2'd1, uni_init_addr, uni_row, uni_col});
          check("uni_issue_cond", 64'(uni_ready && !uni_busy), 64'd1);
        end else begin
          check("uni_addr_hold", 64'(uni_init_addr), 64'(prev_uni_addr));
        end
        if (arr_start) ev_q.push_back({2'd3, 32'd0, 10'd0, 10'd0});
        if (done) begin
          done_cnt++;
          check("done_busy_low", 64'(busy), 64'd0);
        end
        if (err) begin
          err_cnt++;
          check("err_with_done", 64'(done), 64'd1);
        end
      end
      prev_wei_addr = wei_init_addr;
      prev_uni_addr = uni_init_addr;

      if (wei_load) begin
        wei_gap  = rnd_en ? int'($urandom_range(0, 2)) : 0;
        wei_left = rnd_en ? int'($urandom_range(1, 3)) : 3;
      end
      if (wei_gap > 0) begin wei_gap--; wei_busy = 1'b0; end
      else if (wei_left > 0) begin wei_left--; wei_busy = 1'b1; end
      else wei_busy = 1'b0;
      wei_ready = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;

      if (uni_load) begin
        uni_gap  = rnd_en ? int'($urandom_range(0, 2)) : 0;
        uni_left = rnd_en ? int'($urandom_range(1, 3)) : 3;
      end
      if (uni_gap > 0) begin uni_gap--; uni_busy = 1'b0; end
      else if (uni_left > 0) begin uni_left--; uni_busy = 1'b1; end
      else uni_busy = 1'b0;
      uni_ready = !uni_hold && (rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1);

      arr_done = 1'b0;
      if (arr_wait > 0) begin
        arr_wait--;
        if (arr_wait == 0) arr_done = 1'b1;
      end
      if (arr_start) arr_wait = rnd_en ? int'($urandom_range(1, 4)) : 2;
    end
  end

  initial begin
    ev_t e;
    logic [31:0] held;
    int k, dc;
    logic [31:0] ra, rw, ro;
    logic [9:0]  rr, rc;
    logic [7:0]  rn;

    reset = 1'b1; cmd_valid = 1'b0;
    cmd_act_addr = '0; cmd_wei_addr = '0; cmd_out_addr = '0;
    cmd_row = '0; cmd_col = '0; cmd_ntiles = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single tile, fixed 3-cycle busy.
    start_cmd(32'h100, 32'h200, 32'h300, 10'd4, 10'd8, 8'd1);
    finish_cmd();
    e = ev_q[0];
    check("t1_wei_event", 64'(e), 64'({2'd0, 32'h200, 10'd4, 10'd8}));
    e = ev_q[3];
    check("t1_store_event", 64'(e), 64'({2'd2, 32'h300, 10'd4, 10'd8}));
    repeat (3) @(negedge clk);
    check("t1_idle_after", 64'({busy, done}), 64'd0);

    // Three tiles of 16x16.
    start_cmd(32'h2000, 32'h1000, 32'h3000, 10'd16, 10'd16, 8'd3);
    finish_cmd();
    e = ev_q[4];
    check("t2_wei_tile1", 64'(e[51:20]), 64'h1100);
    e = ev_q[8];
    check("t2_wei_tile2", 64'(e[51:20]), 64'h1200);

    // Zero dimensions, back to back with the previous done.
    start_cmd(32'h10, 32'h20, 32'h30, 10'd0, 10'd5, 8'd2);
    finish_cmd();
    start_cmd(32'h10, 32'h20, 32'h30, 10'd7, 10'd0, 8'd1);
    finish_cmd();

    // Flow control: unified buffer not ready while the sequencer waits to load activations.
    uni_hold = 1'b1;
    held = uni_init_addr;
    start_cmd(32'h4000, 32'h5000, 32'h6000, 10'd3, 10'd5, 8'd1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("flow_no_uni_load", 64'(uni_load), 64'd0);
      check("flow_addr_stable", 64'(uni_init_addr), 64'(held));
    end
    check("flow_only_wei_issued", 64'(ev_q.size()), 64'd1);
    uni_hold = 1'b0;
    finish_cmd();

    // Activation pointer wraps past 2^32.
    start_cmd(32'hFFFF_FFF0, 32'h7000, 32'h8000, 10'd4, 10'd4, 8'd2);
    finish_cmd();
    e = ev_q[5];
    check("wrap_act_tile1", 64'(e[51:20]), 64'h0);

    // Reset while the array runs.
    @(negedge clk);
    start_cmd(32'h9000, 32'hA000, 32'hB000, 10'd5, 10'd5, 8'd4);
    k = 0;
    while (!arr_start && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("abort_arr_start_seen", 64'(arr_start), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("abort");
    dc = done_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(dc));

    start_cmd(32'hC000, 32'hD000, 32'hE000, 10'd2, 10'd3, 8'd2);
    finish_cmd();

    // Randomized back-to-back commands with random buffer timing.
    rnd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rw = $urandom; ro = $urandom;
      rr = 10'($urandom_range(0, 12));
      rc = 10'($urandom_range(0, 12));
      rn = 8'($urandom_range(0, 4));
      start_cmd(ra, rw, ro, rr, rc, rn);
      finish_cmd();
    end

    repeat (2) @(negedge clk);
    #1;
    check("done_total", 64'(done_cnt), 64'(exp_done));
    check("err_total", 64'(err_cnt), 64'(exp_err));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
